pcie_ss_axis_mux: RTL and testbench
===================================

// Module: pcie_ss_axis_mux
// PURPOSE
// - N-to-1 AXI-Stream packet multiplexer for PCIe SS TLP streams (pcie_ss_axis_if).
// - Merges NUM_CH sink streams, e.g. TX completions/writes and TXREQ read headers,
//   onto one source stream toward the PCIe SS.
// - Round-robin arbitration at packet boundaries; a granted channel owns the output
//   until its tlast beat is accepted, so packets never interleave.
// PARAMETERS
// - NUM_CH       2     number of sink channels (>=1)
// - TDATA_WIDTH  512   tdata width in bits; tkeep is TDATA_WIDTH/8
// - TUSER_WIDTH  10    tuser_vendor width; passed through opaquely
// PORTS
// - clk                  in   1                 clock; also the clk of every interface instance
// - rst_n                in   1                 asynchronous, active-low reset
// - sink[c].tvalid       in   1                 channel c beat valid, c = 0..NUM_CH-1
// - sink[c].tready       out  1                 channel c beat accepted
// - sink[c].tdata        in   TDATA_WIDTH       channel c data
// - sink[c].tkeep        in   TDATA_WIDTH/8     channel c byte enables
// - sink[c].tlast        in   1                 channel c end of packet
// - sink[c].tuser_vendor in   TUSER_WIDTH       channel c sideband
// - source.tvalid        out  1                 merged beat valid
// - source.tready        in   1                 downstream ready
// - source.tdata/tkeep/tlast/tuser_vendor  out  same widths  merged beat fields
// - sink is a pcie_ss_axis_if.sink modport array [NUM_CH]; source is a pcie_ss_axis_if.source modport
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - source.tvalid=0, all sink tready=0.
//   - Channel lock cleared; RR pointer set so channel 0 has highest priority.
//   - Output data fields are don't-care.
// - Output register (one stage, 1-cycle latency from sink accept to source.tvalid):
//   - can_load = source.tready | ~source.tvalid.
//   - If source.tready: source.tvalid<=0.
//   - On a sink accept: source.* <= granted sink fields, source.tvalid<=1 (overrides clear).
// - Arbitration, evaluated each cycle when unlocked:
//   - grant = first c with sink[c].tvalid, scanning from last_grant+1 modulo NUM_CH.
//   - Unlocked with no valid sink: no grant, no accept.
// - Handshake:
//   - sink[c].tready = can_load & (c == grant); only the granted channel sees tready.
//   - Accept = sink[grant].tvalid & sink[grant].tready.
// - Lock:
//   - On an accept with tlast=0, lock to grant; later beats come only from that channel.
//   - An accept with tlast=1 releases the lock and sets last_grant=grant.
//   - A single-beat packet (tlast=1) never locks.
// - Locked channel drops tvalid: bubbles on source; other channels stay blocked.
// - Backpressure: source.tready=0 with source.tvalid=1 holds source fields stable;
//   all sink tready=0.
// - Simultaneous requests: only one beat per cycle is ever forwarded.
// - NUM_CH=1: pure register slice with the same handshake.
// - Throughput: one beat/cycle sustained while source.tready=1.
// - No beat is dropped, duplicated or reordered within a channel.
// TESTING
// - Ch0 only, 3-beat packet D0,D1,D2 with tlast on D2, source.tready=1:
//   source shows D0..D2 on consecutive cycles, 1-cycle latency, tlast on D2 only.
// - Ch0 and ch1 both send continuous 1-beat packets (tlast=1) after reset:
//   output order ch0,ch1,ch0,ch1...
// - Ch0 holds a 4-beat packet while ch1 is valid throughout:
//   4 ch0 beats contiguous, then the ch1 beat; ch1 tready=0 until ch0's tlast is accepted.
// - source.tready=0 for 5 cycles mid-packet:
//   source fields frozen; sink tready=0; beat 2 appears after tready returns, no loss.
// - Locked ch1 drops tvalid for 2 cycles mid-packet while ch0 is valid:
//   ch0 not granted; ch1 resumes and finishes, then ch0 is granted.
// - rst_n asserted mid-packet (async):
//   source.tvalid=0 immediately; after release, ch0 has priority and the lock is cleared.

Source files
------------

// File: rtl/pcie_ss_axis_mux_if.sv
// PCIe SS AXI-Stream TLP interface: one beat channel with byte keep and opaque vendor sideband.
interface pcie_ss_axis_if #(
  parameter int unsigned TDATA_WIDTH = 512,
  parameter int unsigned TUSER_WIDTH = 10
) (
  input logic clk
);
  logic                       tvalid;
  logic                       tready;
  logic [TDATA_WIDTH-1:0]     tdata;
  logic [TDATA_WIDTH/8-1:0]   tkeep;
  logic                       tlast;
  logic [TUSER_WIDTH-1:0]     tuser_vendor;

  modport sink   (input tvalid, tdata, tkeep, tlast, tuser_vendor, output tready);
  modport source (output tvalid, tdata, tkeep, tlast, tuser_vendor, input tready);
endinterface

// File: rtl/pcie_ss_axis_mux.sv
// N-to-1 AXI-Stream packet mux: round-robin at packet boundaries, one-stage output register.
module pcie_ss_axis_mux #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned TDATA_WIDTH = 512,
  parameter int unsigned TUSER_WIDTH = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  pcie_ss_axis_if.sink   sink [NUM_CH],
  pcie_ss_axis_if.source source
);
  localparam int unsigned KEEP_W = TDATA_WIDTH / 8;
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {ST_OPEN, ST_LOCKED} state_e;

  logic [NUM_CH-1:0]      s_valid;
  logic [NUM_CH-1:0]      s_last;
  logic [NUM_CH-1:0]      s_ready_c;
  logic [TDATA_WIDTH-1:0] s_data [NUM_CH];
  logic [KEEP_W-1:0]      s_keep [NUM_CH];
  logic [TUSER_WIDTH-1:0] s_user [NUM_CH];
  logic                   src_ready;

  state_e          state_q, state_d;
  logic [CH_W-1:0] lock_ch_q, lock_ch_d;
  logic [CH_W-1:0] last_grant_q, last_grant_d;
  logic [CH_W-1:0] arb_ch_c, grant_c;
  logic            arb_vld_c, grant_vld_c, can_load_c, accept_c;

  logic                   tvalid_q;
  logic [TDATA_WIDTH-1:0] tdata_q;
  logic [KEEP_W-1:0]      tkeep_q;
  logic                   tlast_q;
  logic [TUSER_WIDTH-1:0] tuser_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_sink
    assign s_valid[c]    = sink[c].tvalid;
    assign s_last[c]     = sink[c].tlast;
    assign s_data[c]     = sink[c].tdata;
    assign s_keep[c]     = sink[c].tkeep;
    assign s_user[c]     = sink[c].tuser_vendor;
    assign sink[c].tready = s_ready_c[c];
  end

  assign src_ready           = source.tready;
  assign source.tvalid       = tvalid_q;
  assign source.tdata        = tdata_q;
  assign source.tkeep        = tkeep_q;
  assign source.tlast        = tlast_q;
  assign source.tuser_vendor = tuser_q;

  // Round-robin scan starting after last_grant; descending loop so the nearest requester wins.
  always_comb begin
    int unsigned idx;
    arb_ch_c  = last_grant_q;
    arb_vld_c = 1'b0;
    idx       = 0;
    for (int unsigned i = NUM_CH; i >= 1; i--) begin
      idx = (32'(last_grant_q) + i) % NUM_CH;
      if (s_valid[CH_W'(idx)]) begin
        arb_ch_c  = CH_W'(idx);
        arb_vld_c = 1'b1;
      end
    end
  end

  // Lock FSM: next state, grant selection and sink handshake.
  always_comb begin
    state_d      = state_q;
    lock_ch_d    = lock_ch_q;
    last_grant_d = last_grant_q;
    grant_c      = arb_ch_c;
    grant_vld_c  = arb_vld_c;
    s_ready_c    = '0;
    can_load_c   = src_ready | ~tvalid_q;
    if (state_q == ST_LOCKED) begin
      grant_c     = lock_ch_q;
      grant_vld_c = 1'b1;
    end
    // rst_n gating keeps every tready low while reset is held.
    if (rst_n && can_load_c && grant_vld_c) begin
      s_ready_c[grant_c] = 1'b1;
    end
    accept_c = s_ready_c[grant_c] & s_valid[grant_c];
    if (accept_c) begin
      if (s_last[grant_c]) begin
        state_d      = ST_OPEN;
        last_grant_d = grant_c;
      end else begin
        state_d   = ST_LOCKED;
        lock_ch_d = grant_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_OPEN;
      lock_ch_q    <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
    end else begin
      state_q      <= state_d;
      lock_ch_q    <= lock_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Output slice: a new accept overrides the clear on downstream ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= '0;
    end else begin
      if (src_ready) begin
        tvalid_q <= 1'b0;
      end
      if (accept_c) begin
        tvalid_q <= 1'b1;
        tdata_q  <= s_data[grant_c];
        tkeep_q  <= s_keep[grant_c];
        tlast_q  <= s_last[grant_c];
        tuser_q  <= s_user[grant_c];
      end
    end
  end
endmodule

// File: tb/tb_pcie_ss_axis_mux.sv
// Scoreboard bench for pcie_ss_axis_mux: per-channel drivers feed queues, a monitor pops expected beats.
module tb_pcie_ss_axis_mux;
  localparam int unsigned NCH = 2;
  localparam int unsigned DW  = 64;
  localparam int unsigned UW  = 10;
  localparam int unsigned KW  = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic src_rdy = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  beat_t exp_q [$];
  beat_t txq [NCH][$];
  bit    hold [NCH];
  logic  s_vld [NCH];
  logic  s_rdy [NCH];
  int    acc_cnt [NCH];
  int    first_acc_cyc [NCH];
  int    first_rdy [NCH];
  int    obs_cyc [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pcie_ss_axis_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) sink_if [NCH] (.clk(clk));
  pcie_ss_axis_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) src_if (.clk(clk));

  pcie_ss_axis_mux #(.NUM_CH(NCH), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sink   (sink_if),
    .source (src_if)
  );

  assign src_if.tready = src_rdy;

  // Per-channel driver: presents the queue head, pops it once the handshake was seen.
  for (genvar g = 0; g < NCH; g++) begin : g_drv
    assign s_vld[g] = sink_if[g].tvalid;
    assign s_rdy[g] = sink_if[g].tready;
    initial begin
      bit    took;
      beat_t b;
      sink_if[g].tvalid       = 1'b0;
      sink_if[g].tdata        = '0;
      sink_if[g].tkeep        = '0;
      sink_if[g].tlast        = 1'b0;
      sink_if[g].tuser_vendor = '0;
      forever begin
        @(negedge clk);
        took = sink_if[g].tvalid && sink_if[g].tready && rst_n;
        @(posedge clk);
        #1;
        if (took && txq[g].size() > 0) void'(txq[g].pop_front());
        if (txq[g].size() > 0 && !hold[g]) begin
          b = txq[g][0];
          sink_if[g].tdata        = b.data;
          sink_if[g].tkeep        = b.keep;
          sink_if[g].tlast        = b.last;
          sink_if[g].tuser_vendor = b.user;
          sink_if[g].tvalid       = 1'b1;
        end else begin
          sink_if[g].tvalid = 1'b0;
        end
      end
    end
  end

  // Monitor: sink statistics plus scoreboard compare of every source beat.
  always @(negedge clk) begin
    beat_t e;
    beat_t o;
    if (rst_n) begin
      for (int g = 0; g < NCH; g++)
        if (s_rdy[g] && first_rdy[g] < 0) first_rdy[g] = acc_cnt[NCH-1-g];
      for (int g = 0; g < NCH; g++)
        if (s_vld[g] && s_rdy[g]) begin
          if (first_acc_cyc[g] < 0) first_acc_cyc[g] = cyc;
          acc_cnt[g]++;
        end
      if (src_if.tvalid && src_if.tready) begin
        o.data = src_if.tdata;
        o.keep = src_if.tkeep;
        o.user = src_if.tuser_vendor;
        o.last = src_if.tlast;
        obs_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: unexpected beat data=%h last=%b", o.data, o.last);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin
            errors++;
            $display("FAIL sb_beat: got data=%h keep=%h user=%h last=%b, want data=%h keep=%h user=%h last=%b",
                     o.data, o.keep, o.user, o.last, e.data, e.keep, e.user, e.last);
          end
        end
      end
    end
  end

  task automatic send(input int ch, input int idx, input bit last);
    beat_t b;
    b.data = {8'(ch), 8'(idx), 16'($urandom), 32'($urandom)};
    b.keep = KW'($urandom);
    b.user = UW'($urandom);
    b.last = last;
    txq[ch].push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic clear_stats();
    for (int g = 0; g < NCH; g++) begin
      acc_cnt[g]       = 0;
      first_acc_cyc[g] = -1;
      first_rdy[g]     = -1;
    end
    obs_cyc.delete();
  endtask

  task automatic flush();
    for (int g = 0; g < NCH; g++) txq[g].delete();
    exp_q.delete();
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    ok = (exp_q.size() == 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    flush();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bit ok;
    @(posedge clk);
    #2;
    clear_stats();
    src_rdy = 1'b1;
    send(0, 0, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (src_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", src_if.tvalid); end
    checks++;
    if (s_rdy[0] !== 1'b0) begin errors++; $display("FAIL reset_tready0: got %b want 0", s_rdy[0]); end
    checks++;
    if (s_rdy[1] !== 1'b0) begin errors++; $display("FAIL reset_tready1: got %b want 0", s_rdy[1]); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    wait_drain(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_drain: %0d beats left want 0", exp_q.size()); end
  endtask

  task automatic test_single();
    bit ok;
    clear_stats();
    send(0, 0, 1'b0);
    send(0, 1, 1'b0);
    send(0, 2, 1'b1);
    wait_drain(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_drain: %0d beats left want 0", exp_q.size()); end
    checks++;
    if (obs_cyc.size() != 3) begin errors++; $display("FAIL single_count: got %0d want 3", obs_cyc.size()); end
    if (obs_cyc.size() == 3) begin
      checks++;
      if (obs_cyc[0] != first_acc_cyc[0] + 1) begin
        errors++; $display("FAIL single_latency: out cyc %0d want %0d", obs_cyc[0], first_acc_cyc[0] + 1);
      end
      checks++;
      if (obs_cyc[2] - obs_cyc[0] != 2) begin
        errors++; $display("FAIL single_contig: span %0d want 2", obs_cyc[2] - obs_cyc[0]);
      end
    end
  endtask

  task automatic test_rr();
    bit ok;
    apply_reset();
    clear_stats();
    for (int i = 0; i < 4; i++) begin
      send(0, i, 1'b1);
      send(1, i, 1'b1);
    end
    wait_drain(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_drain: %0d beats left want 0", exp_q.size()); end
  endtask

  task automatic test_lock();
    bit ok;
    clear_stats();
    for (int i = 0; i < 4; i++) send(0, i, i == 3);
    send(1, 0, 1'b1);
    wait_drain(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL lock_drain: %0d beats left want 0", exp_q.size()); end
    checks++;
    if (first_rdy[1] != 4) begin
      errors++; $display("FAIL lock_ch1_ready: ch1 ready after %0d ch0 beats want 4", first_rdy[1]);
    end
  endtask

  task automatic test_backpressure();
    bit    ok;
    beat_t held;
    int    n;
    clear_stats();
    src_rdy = 1'b1;
    for (int i = 0; i < 4; i++) send(0, i, i == 3);
    held = exp_q[1];
    n = 0;
    while (obs_cyc.size() < 1 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (obs_cyc.size() < 1) begin errors++; $display("FAIL bp_start: got %0d beats want 1", obs_cyc.size()); end
    src_rdy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (src_if.tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid: got %b want 1", src_if.tvalid); end
      checks++;
      if (src_if.tdata !== held.data) begin errors++; $display("FAIL bp_tdata: got %h want %h", src_if.tdata, held.data); end
      checks++;
      if (s_rdy[0] !== 1'b0) begin errors++; $display("FAIL bp_tready0: got %b want 0", s_rdy[0]); end
      checks++;
      if (s_rdy[1] !== 1'b0) begin errors++; $display("FAIL bp_tready1: got %b want 0", s_rdy[1]); end
      @(posedge clk);
      #2;
    end
    src_rdy = 1'b1;
    wait_drain(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_drain: %0d beats left want 0", exp_q.size()); end
  endtask

  task automatic test_drop();
    bit ok;
    int n;
    clear_stats();
    for (int i = 0; i < 4; i++) send(1, i, i == 3);
    n = 0;
    while (acc_cnt[1] < 1 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (acc_cnt[1] < 1) begin errors++; $display("FAIL drop_start: ch1 accepts %0d want >=1", acc_cnt[1]); end
    send(0, 0, 1'b1);
    send(0, 1, 1'b1);
    hold[1] = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    hold[1] = 1'b0;
    wait_drain(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL drop_drain: %0d beats left want 0", exp_q.size()); end
    checks++;
    if (first_rdy[0] != 4) begin
      errors++; $display("FAIL drop_ch0_ready: ch0 ready after %0d ch1 beats want 4", first_rdy[0]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    clear_stats();
    for (int i = 0; i < 4; i++) send(1, i, i == 3);
    n = 0;
    while (acc_cnt[1] < 2 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (acc_cnt[1] < 2) begin errors++; $display("FAIL rstmid_start: ch1 accepts %0d want >=2", acc_cnt[1]); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (src_if.tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid: got %b want 0", src_if.tvalid); end
    checks++;
    if (s_rdy[0] !== 1'b0 || s_rdy[1] !== 1'b0) begin
      errors++; $display("FAIL rstmid_tready: got %b%b want 00", s_rdy[1], s_rdy[0]);
    end
    flush();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    clear_stats();
    send(0, 9, 1'b1);
    send(1, 9, 1'b1);
    wait_drain(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_drain: %0d beats left want 0", exp_q.size()); end
  endtask

  initial begin
    for (int g = 0; g < NCH; g++) hold[g] = 1'b0;
    clear_stats();
    test_reset();
    test_single();
    test_rr();
    test_lock();
    test_backpressure();
    test_drop();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
